// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB walk, PC and
// instruction-memory handshake, instruction latch, register-file write strobe,
// HALT on decoder request and FAULT on fetch timeout.
// Optional build macro: SEQ_STEP_EN adds the step port and a STEP_WAIT state
// so that each instruction after the first needs a step pulse.
`ifndef InstrWidth
`define InstrWidth 16
`endif

module instr_sequencer #(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned FETCH_TMO = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [`InstrWidth-1:0] imem_rdata,
  output logic [`InstrWidth-1:0] instr,
  input  logic                   dec_halted,
  input  logic                   dec_reg_write_en,
  output logic                   reg_we,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault
`ifdef SEQ_STEP_EN
  ,
  input  logic                   step
`endif
);

  localparam int unsigned TMO_W = (FETCH_TMO < 2) ? 1 : $clog2(FETCH_TMO + 1);
  // Counter value on the last tolerated no-ack cycle; the timeout fires when a
  // further no-ack cycle would make the count reach FETCH_TMO.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((FETCH_TMO == 0) ? 0 : FETCH_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
`ifdef SEQ_STEP_EN
    ,
    S_STEP_WAIT
`endif
  } state_t;

  state_t           state, state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (FETCH_TMO != 0) && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)     state_nx = S_DECODE;
        else if (tmo_hit) state_nx = S_FAULT;
      end
      S_DECODE: begin
        if (dec_halted) state_nx = S_HALT;
        else            state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        reg_we = dec_reg_write_en;
`ifdef SEQ_STEP_EN
        state_nx = run ? S_STEP_WAIT : S_IDLE;
`else
        state_nx = run ? S_FETCH : S_IDLE;
`endif
      end
`ifdef SEQ_STEP_EN
      S_STEP_WAIT: begin
        if (!run)      state_nx = S_IDLE;
        else if (step) state_nx = S_FETCH;
      end
`endif
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc;

  // PC advance in WB, instruction latch on accepted fetch, fetch timeout count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= PC_WIDTH'(RESET_PC);
      instr   <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) instr <= imem_rdata;
      if (state == S_WB) pc <= pc + PC_WIDTH'(1);
      if (state == S_FETCH && !imem_ack && !tmo_hit && FETCH_TMO != 0)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      else
        tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer (PC_WIDTH=4, FETCH_TMO=4).
// A transaction-level model predicts every cycle of each instruction from the
// handshake delay, the fetched word and the run level; a small decoder stub
// derives dec_halted / dec_reg_write_en from the latched instruction.
`ifndef InstrWidth
`define InstrWidth 16
`endif

module tb_instr_sequencer;

  localparam int unsigned PCW  = 4;
  localparam int unsigned TMO  = 4;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   run;
  logic                   imem_req;
  logic [PCW-1:0]         imem_addr;
  logic                   imem_ack;
  logic [`InstrWidth-1:0] imem_rdata;
  logic [`InstrWidth-1:0] instr;
  logic                   dec_halted;
  logic                   dec_reg_write_en;
  logic                   reg_we;
  logic [PCW-1:0]         pc;
  logic                   busy;
  logic                   halted;
  logic                   fault;
  logic                   step;

  int n_vec = 0;
  int n_err = 0;

  int                     m_pc;
  logic [`InstrWidth-1:0] m_instr;
  logic                   in_idle;

  instr_sequencer #(
    .PC_WIDTH (PCW),
    .RESET_PC (0),
    .FETCH_TMO(TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .dec_halted      (dec_halted),
    .dec_reg_write_en(dec_reg_write_en),
    .reg_we          (reg_we),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .fault           (fault)
`ifdef SEQ_STEP_EN
    ,
    .step            (step)
`endif
  );

  always #5 clk = ~clk;

  // Decoder stub: opcodes 1..7 write the register file, 4'hF halts.
  function automatic logic writes(input logic [`InstrWidth-1:0] w);
    return (w[15:12] >= 4'h1) && (w[15:12] <= 4'h7);
  endfunction

  assign dec_halted       = (instr[15:12] == OP_HALT);
  assign dec_reg_write_en = writes(instr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; step = 1'b0;
    imem_rdata = `InstrWidth'($urandom);
    #2;
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_outs", {imem_req, reg_we, busy, halted, fault}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_instr = '0; in_idle = 1'b1;
  endtask

  task automatic start_from_idle(input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) begin
      check("idle_outs", {imem_req, reg_we, busy, halted, fault}, 0);
      check("idle_pc", pc, m_pc);
      run = 1'b0;
      imem_ack = 1'($urandom);
      @(negedge clk);
    end
    check("idle_busy", busy, 0);
    run = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    in_idle = 1'b0;
  endtask

  task automatic fetch(input int delay, input logic [`InstrWidth-1:0] word);
    for (int i = 0; i <= delay; i++) begin
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, m_pc);
      check("fetch_instr_hold", instr, m_instr);
      check("fetch_we", {reg_we, busy}, 2'b01);
      imem_ack   = (i == delay);
      imem_rdata = (i == delay) ? word : `InstrWidth'($urandom);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    m_instr  = word;
  endtask

  // DECODE, EXEC, WB and the transition out of WB.
  task automatic finish_instr(input logic run_after);
    check("dec_req", imem_req, 0);
    check("dec_instr", instr, m_instr);
    check("dec_we", {reg_we, busy}, 2'b01);
    imem_ack = 1'($urandom); imem_rdata = `InstrWidth'($urandom);
    @(negedge clk);
    if (m_instr[15:12] == OP_HALT) begin
      imem_ack = 1'b0;
      check("halt_flags", {halted, busy, fault, imem_req, reg_we}, 5'b10000);
      check("halt_pc", pc, m_pc);
      return;
    end
    check("exec_we", {reg_we, busy, imem_req}, 3'b010);
    check("exec_instr", instr, m_instr);
    run = run_after;
    imem_ack = 1'($urandom); imem_rdata = `InstrWidth'($urandom);
    @(negedge clk);
    check("wb_we", reg_we, writes(m_instr));
    check("wb_pc", pc, m_pc);
    check("wb_busy", {busy, imem_req}, 2'b10);
    imem_ack = 1'b0;
    @(negedge clk);
    m_pc = (m_pc + 1) % (1 << PCW);
    check("post_wb_pc", pc, m_pc);
    if (!run_after) begin
      in_idle = 1'b1;
      return;
    end
`ifdef SEQ_STEP_EN
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      check("stepw_outs", {busy, imem_req, reg_we}, 3'b100);
      step = 1'b0;
      @(negedge clk);
    end
    check("stepw_busy", busy, 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`endif
  endtask

  task automatic do_instr(input int delay, input logic [`InstrWidth-1:0] word,
                          input logic run_after);
    if (in_idle) start_from_idle(int'($urandom_range(0, 2)));
    fetch(delay, word);
    finish_instr(run_after);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [`InstrWidth-1:0] w;
    @(negedge clk);
    do_reset();

    // Back-to-back zero-wait ADDs, then waited fetches.
    do_instr(0, {OP_ADD, 12'h0}, 1'b1);
    do_instr(0, {OP_ADD, 12'h0}, 1'b1);
    do_instr(3, {4'h2, 12'h5A5}, 1'b1);
    do_instr(1, {4'h9, 12'h123}, 1'b0);

    // Random instruction stream; pc wraps past 15 several times.
    for (int n = 0; n < 60; n++) begin
      w = `InstrWidth'($urandom);
      if (w[15:12] == OP_HALT) w[15:12] = OP_ADD;
      do_instr(int'($urandom_range(0, 3)), w, ($urandom_range(0, 3) != 0));
    end

    // Wrap from 15 to 0 with run dropped during EXEC.
    do_reset();
    for (int n = 0; n < 15; n++) do_instr(0, {OP_ADD, 12'h0}, 1'b1);
    check("wrap_pre_pc", pc, 15);
    do_instr(0, {OP_ADD, 12'h0}, 1'b0);
    check("wrap_pc", pc, 0);
    start_from_idle(2);
    fetch(0, {OP_ADD, 12'h1});
    finish_instr(1'b0);

    // HALT at pc 5; run toggling has no effect.
    do_reset();
    for (int n = 0; n < 5; n++) do_instr(int'($urandom_range(0, 2)), {OP_ADD, 12'h7}, 1'b1);
    do_instr(0, {OP_HALT, 12'h0}, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom); imem_ack = 1'($urandom);
      @(negedge clk);
      check("halt_stay", {halted, busy, imem_req, reg_we}, 4'b1000);
      check("halt_stay_pc", pc, 5);
    end

    // Asynchronous reset in the middle of a FETCH.
    do_reset();
    for (int n = 0; n < 3; n++) do_instr(0, {4'h3, 12'hABC}, 1'b1);
    check("mid_req", imem_req, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_outs", {imem_req, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1; m_pc = 0; m_instr = '0; in_idle = 1'b1;

    // Fetch timeout: four no-ack cycles then FAULT.
    start_from_idle(1);
    for (int i = 0; i < int'(TMO); i++) begin
      check("tmo_req", imem_req, 1);
      check("tmo_fault", fault, 0);
      imem_ack = 1'b0;
      @(negedge clk);
    end
    check("tmo_flags", {fault, busy, imem_req, halted}, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom); imem_ack = 1'($urandom);
      @(negedge clk);
      check("fault_stay", {fault, busy, imem_req}, 3'b100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
